// File: rtl/crypto_key_scheduler_pkg.sv
// Shared definitions for the crypto key scheduler: FSM state encoding,
// key/epoch widths and default stream widths.
package crypto_key_scheduler_pkg;

   localparam int KEY_WIDTH       = 32;
   localparam int EPOCH_WIDTH     = 8;
   localparam int DEF_DATA_WIDTH  = 256;
   localparam int DEF_TUSER_WIDTH = 128;

   typedef enum logic {
      ST_SOP = 1'b0,
      ST_MID = 1'b1
   } state_t;

   typedef logic [KEY_WIDTH-1:0] key_t;

endpackage

// File: rtl/crypto_key_scheduler_if.sv
// AXI4-Stream bundle used on both sides of the key scheduler.
// master drives the beat, slave returns tready.
interface crypto_key_scheduler_if
   import crypto_key_scheduler_pkg::*;
#(
   parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
   parameter int TUSER_WIDTH = DEF_TUSER_WIDTH
);
   logic [DATA_WIDTH-1:0]   tdata;
   logic [DATA_WIDTH/8-1:0] tstrb;
   logic [TUSER_WIDTH-1:0]  tuser;
   logic                    tvalid;
   logic                    tlast;
   logic                    tready;

   modport master (output tdata, tstrb, tuser, tvalid, tlast, input tready);
   modport slave  (input tdata, tstrb, tuser, tvalid, tlast, output tready);
endinterface

// File: rtl/crypto_key_scheduler_axis_reg_slice.sv
// Single-stage valid/ready register slice carrying an opaque payload.
// Full throughput: a new beat is taken whenever the output is empty or drained.
module crypto_key_scheduler_axis_reg_slice #(
   parameter int WIDTH = 1
) (
   input  logic             axi_aclk,
   input  logic             axi_reset,
   input  logic             s_valid,
   output logic             s_ready,
   input  logic [WIDTH-1:0] s_payload,
   output logic             m_valid,
   input  logic             m_ready,
   output logic [WIDTH-1:0] m_payload
);

   assign s_ready = !m_valid || m_ready;

   // Output register: load on every upstream transfer, hold while stalled.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of block ordering.
   always_ff @(posedge axi_aclk or posedge axi_reset) begin
      if (axi_reset) begin
         m_valid   <= 1'b0;
         m_payload <= '0;
      end else if (s_ready) begin
         m_valid <= s_valid;
         if (s_valid) begin
            m_payload <= s_payload;
         end
      end
   end

endmodule

// File: rtl/crypto_key_scheduler.sv
// Per-interface key scheduler in front of the crypto datapath.
// Selects a 32-bit key on each packet's first beat from the source-port
// one-hot in tuser and presents it beat-aligned with a registered stream.
// Host key updates land in a shadow table; a commit copies shadow to active
// only at a packet boundary.
// Optional build macro CRYPTO_KEY_STATS_EN adds pkt_count / nosrc_count.
module crypto_key_scheduler
   import crypto_key_scheduler_pkg::*;
#(
   parameter int C_AXIS_DATA_WIDTH  = DEF_DATA_WIDTH,
   parameter int C_AXIS_TUSER_WIDTH = DEF_TUSER_WIDTH,
   parameter int NUM_KEYS           = 4,
   parameter int SRC_PORT_POS       = 16,
   localparam int IDX_WIDTH         = $clog2(NUM_KEYS)
) (
   input  logic                          axi_aclk,
   input  logic                          axi_reset,
   crypto_key_scheduler_if.slave         s_axis,
   crypto_key_scheduler_if.master        m_axis,
   output key_t                          m_key,
   input  logic                          cfg_wr_en,
   input  logic [IDX_WIDTH-1:0]          cfg_wr_idx,
   input  key_t                          cfg_wr_key,
   input  logic                          cfg_commit,
   output logic                          commit_pending,
   output logic [EPOCH_WIDTH-1:0]        key_epoch
`ifdef CRYPTO_KEY_STATS_EN
   ,
   output logic [31:0]                   pkt_count,
   output logic [15:0]                   nosrc_count
`endif
);

   localparam int F_WIDTH = 2 * NUM_KEYS;
   localparam int PAYLOAD_WIDTH = 1 + C_AXIS_TUSER_WIDTH + C_AXIS_DATA_WIDTH/8
                                + C_AXIS_DATA_WIDTH + KEY_WIDTH;

   key_t                   active_tbl [NUM_KEYS];
   key_t                   shadow_tbl [NUM_KEYS];
   state_t                 state;
   key_t                   cur_key;
   key_t                   sel_key;
   key_t                   beat_key;
   logic [F_WIDTH-1:0]     src_field;
   logic [IDX_WIDTH-1:0]   src_idx;
   logic                   accept;
   logic                   next_is_sop;
   logic                   swap_now;
   logic [PAYLOAD_WIDTH-1:0] s_payload;
   logic [PAYLOAD_WIDTH-1:0] m_payload;

   assign accept    = s_axis.tvalid && s_axis.tready;
   assign src_field = s_axis.tuser[SRC_PORT_POS +: F_WIDTH];

   // Lowest set source bit wins; MAC and DMA of one interface share a key.
   // NOTE: the default assignment first keeps this block free of latches.
   always_comb begin
      src_idx = '0;
      for (int i = F_WIDTH - 1; i >= 0; i--) begin
         if (src_field[i]) begin
            src_idx = IDX_WIDTH'(i >> 1);
         end
      end
   end

   assign sel_key     = active_tbl[src_idx];
   assign beat_key    = (state == ST_SOP) ? sel_key : cur_key;
   assign next_is_sop = accept ? s_axis.tlast : (state == ST_SOP);
   assign swap_now    = commit_pending && !cfg_commit && next_is_sop;

   // Packet FSM: latch the key on the first beat, reuse it for the rest.
   always_ff @(posedge axi_aclk or posedge axi_reset) begin
      if (axi_reset) begin
         state   <= ST_SOP;
         cur_key <= '0;
      end else if (accept) begin
         case (state)
            ST_SOP: begin
               cur_key <= sel_key;
               state   <= s_axis.tlast ? ST_SOP : ST_MID;
            end
            ST_MID: begin
               if (s_axis.tlast) begin
                  state <= ST_SOP;
               end
            end
         endcase
      end
   end

   // Key tables and commit: shadow writes any time, swap only at a boundary.
   // NOTE: both tables are cleared by reset on purpose (keys must read as zero
   // after reset), which is why they are flops rather than a RAM.
   always_ff @(posedge axi_aclk or posedge axi_reset) begin
      if (axi_reset) begin
         for (int i = 0; i < NUM_KEYS; i++) begin
            active_tbl[i] <= '0;
            shadow_tbl[i] <= '0;
         end
         commit_pending <= 1'b0;
         key_epoch      <= '0;
      end else begin
         if (cfg_wr_en) begin
            shadow_tbl[cfg_wr_idx] <= cfg_wr_key;
         end
         if (swap_now) begin
            for (int i = 0; i < NUM_KEYS; i++) begin
               active_tbl[i] <= shadow_tbl[i];
            end
            key_epoch <= key_epoch + 1'b1;
         end
         if (cfg_commit) begin
            commit_pending <= 1'b1;
         end else if (swap_now) begin
            commit_pending <= 1'b0;
         end
      end
   end

`ifdef CRYPTO_KEY_STATS_EN
   // Statistics: completed packets and first beats without a source port.
   always_ff @(posedge axi_aclk or posedge axi_reset) begin
      if (axi_reset) begin
         pkt_count   <= '0;
         nosrc_count <= '0;
      end else if (accept) begin
         if (s_axis.tlast) begin
            pkt_count <= pkt_count + 32'd1;
         end
         if (state == ST_SOP && src_field == '0 && nosrc_count != 16'hFFFF) begin
            nosrc_count <= nosrc_count + 16'd1;
         end
      end
   end
`endif

   assign s_payload = {s_axis.tlast, s_axis.tuser, s_axis.tstrb, s_axis.tdata, beat_key};
   assign {m_axis.tlast, m_axis.tuser, m_axis.tstrb, m_axis.tdata, m_key} = m_payload;

   crypto_key_scheduler_axis_reg_slice #(
      .WIDTH (PAYLOAD_WIDTH)
   ) u_axis_reg_slice (
      .axi_aclk  (axi_aclk),
      .axi_reset (axi_reset),
      .s_valid   (s_axis.tvalid),
      .s_ready   (s_axis.tready),
      .s_payload (s_payload),
      .m_valid   (m_axis.tvalid),
      .m_ready   (m_axis.tready),
      .m_payload (m_payload)
   );

endmodule

// File: tb/tb_crypto_key_scheduler.sv
// Scoreboard bench for crypto_key_scheduler: a reference model pushes the
// expected beat when a beat is accepted; a monitor pops on each output transfer.
module tb_crypto_key_scheduler;
   import crypto_key_scheduler_pkg::*;

   localparam int DW  = 256;
   localparam int UW  = 128;
   localparam int NK  = 4;
   localparam int SPP = 16;

   logic axi_aclk  = 1'b0;
   logic axi_reset = 1'b1;
   always #5 axi_aclk = ~axi_aclk;

   crypto_key_scheduler_if #(.DATA_WIDTH(DW), .TUSER_WIDTH(UW)) s_if ();
   crypto_key_scheduler_if #(.DATA_WIDTH(DW), .TUSER_WIDTH(UW)) m_if ();

   logic [KEY_WIDTH-1:0] m_key;
   logic                 cfg_wr_en  = 1'b0;
   logic [1:0]           cfg_wr_idx = '0;
   logic [KEY_WIDTH-1:0] cfg_wr_key = '0;
   logic                 cfg_commit = 1'b0;
   logic                 commit_pending;
   logic [7:0]           key_epoch;
`ifdef CRYPTO_KEY_STATS_EN
   logic [31:0]          pkt_count;
   logic [15:0]          nosrc_count;
`endif

   crypto_key_scheduler #(
      .C_AXIS_DATA_WIDTH  (DW),
      .C_AXIS_TUSER_WIDTH (UW),
      .NUM_KEYS           (NK),
      .SRC_PORT_POS       (SPP)
   ) dut (
      .axi_aclk       (axi_aclk),
      .axi_reset      (axi_reset),
      .s_axis         (s_if),
      .m_axis         (m_if),
      .m_key          (m_key),
      .cfg_wr_en      (cfg_wr_en),
      .cfg_wr_idx     (cfg_wr_idx),
      .cfg_wr_key     (cfg_wr_key),
      .cfg_commit     (cfg_commit),
      .commit_pending (commit_pending),
      .key_epoch      (key_epoch)
`ifdef CRYPTO_KEY_STATS_EN
      ,
      .pkt_count      (pkt_count),
      .nosrc_count    (nosrc_count)
`endif
   );

   typedef struct {
      logic [DW-1:0]   data;
      logic [DW/8-1:0] strb;
      logic [UW-1:0]   user;
      logic            last;
      logic [31:0]     key;
   } beat_t;

   beat_t exp_q[$];
   bit    rdy_pat[$];
   bit    rand_mode = 1'b0;
   int    n_cmp = 0;
   int    n_fail = 0;

   // reference model state
   logic [31:0] act_m [NK];
   logic [31:0] sh_m  [NK];
   logic [31:0] cur_m;
   bit          in_pkt_m, full_m, pend_m, acc_flag;
   logic [7:0]  epoch_m;
   int          pkt_m, nosrc_m;

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < NK; i++) begin
         act_m[i] = '0;
         sh_m[i]  = '0;
      end
      cur_m = '0; in_pkt_m = 0; full_m = 0; pend_m = 0; acc_flag = 0;
      epoch_m = '0; pkt_m = 0; nosrc_m = 0;
   endtask

   // Spec rule: first set bit of the 2*NK-bit field, divided by two; none -> entry 0.
   function automatic logic [31:0] lookup(input logic [UW-1:0] user);
      logic [2*NK-1:0] f;
      f = user[SPP +: 2*NK];
      for (int i = 0; i < 2*NK; i++) begin
         if (f[i]) return act_m[i/2];
      end
      return act_m[0];
   endfunction

   // Evaluated at the negative edge: compare registered outputs, then predict the next edge.
   task automatic model_eval();
      bit ready_m, acc, next_in;
      beat_t b;
      ready_m = !full_m || m_if.tready;
      check("s_tready", s_if.tready, ready_m);
      check("m_tvalid", m_if.tvalid, full_m);
      check("commit_pending", commit_pending, pend_m);
      check("key_epoch", key_epoch, epoch_m);
`ifdef CRYPTO_KEY_STATS_EN
      check("pkt_count", pkt_count, pkt_m);
      check("nosrc_count", nosrc_count, nosrc_m);
`endif
      acc = s_if.tvalid && ready_m;
      next_in = in_pkt_m;
      if (acc) begin
         if (!in_pkt_m) begin
            cur_m = lookup(s_if.tuser);
            if (s_if.tuser[SPP +: 2*NK] == '0 && nosrc_m < 65535) nosrc_m++;
         end
         b.data = s_if.tdata; b.strb = s_if.tstrb; b.user = s_if.tuser;
         b.last = s_if.tlast; b.key = cur_m;
         exp_q.push_back(b);
         if (s_if.tlast) pkt_m++;
         next_in = !s_if.tlast;
      end
      full_m = acc ? 1'b1 : (m_if.tready ? 1'b0 : full_m);
      if (pend_m && !cfg_commit && !next_in) begin
         for (int i = 0; i < NK; i++) act_m[i] = sh_m[i];
         pend_m = 0;
         epoch_m = epoch_m + 8'd1;
      end
      if (cfg_wr_en) sh_m[cfg_wr_idx] = cfg_wr_key;
      if (cfg_commit) pend_m = 1;
      in_pkt_m = next_in;
      acc_flag = acc;
   endtask

   task automatic cycle();
      @(negedge axi_aclk);
      model_eval();
      @(posedge axi_aclk);
      #1;
      cfg_wr_en  = 1'b0;
      cfg_commit = 1'b0;
      if (rdy_pat.size() > 0) begin
         m_if.tready = rdy_pat.pop_front();
      end else if (rand_mode) begin
         m_if.tready = ($urandom_range(3) != 0);
         if ($urandom_range(4) == 0) begin
            cfg_wr_en  = 1'b1;
            cfg_wr_idx = 2'($urandom_range(NK-1));
            cfg_wr_key = $urandom;
         end
         cfg_commit = ($urandom_range(9) == 0);
      end else begin
         m_if.tready = 1'b1;
      end
   endtask

   task automatic idle(input int n);
      s_if.tvalid = 1'b0;
      repeat (n) cycle();
   endtask

   task automatic send_beat(input logic [UW-1:0] user, input bit last);
      int k;
      for (int w = 0; w < DW/32; w++) s_if.tdata[w*32 +: 32] = $urandom;
      s_if.tstrb  = $urandom;
      s_if.tuser  = user;
      s_if.tlast  = last;
      s_if.tvalid = 1'b1;
      k = 0;
      do begin
         cycle();
         k++;
      end while (!acc_flag && k < 64);
      if (!acc_flag) begin
         n_cmp++; n_fail++;
         $display("FAIL send_timeout: beat not accepted within %0d cycles", k);
      end
   endtask

   function automatic logic [UW-1:0] mk_user(input logic [7:0] field);
      logic [UW-1:0] u;
      for (int w = 0; w < UW/32; w++) u[w*32 +: 32] = $urandom;
      u[SPP +: 2*NK] = field;
      return u;
   endfunction

   task automatic send_pkt(input int len, input logic [7:0] field);
      logic [UW-1:0] u;
      u = mk_user(field);
      for (int i = 0; i < len; i++) send_beat(u, i == len - 1);
   endtask

   // Monitor: pops on each output transfer and checks stall stability.
   initial begin : monitor
      bit    stalled;
      beat_t held, e;
      stalled = 0;
      forever begin
         @(negedge axi_aclk);
         if (!m_if.tvalid) begin
            stalled = 0;
         end else begin
            if (stalled) begin
               check("stall_tdata", m_if.tdata, held.data);
               check("stall_key", m_key, held.key);
            end
            if (m_if.tready) begin
               stalled = 0;
               if (exp_q.size() == 0) begin
                  n_cmp++; n_fail++;
                  $display("FAIL unexpected_beat: got tdata %0h expected no beat", m_if.tdata);
               end else begin
                  e = exp_q.pop_front();
                  check("out_tdata", m_if.tdata, e.data);
                  check("out_tstrb", m_if.tstrb, e.strb);
                  check("out_tuser", m_if.tuser, e.user);
                  check("out_tlast", m_if.tlast, e.last);
                  check("out_key", m_key, e.key);
               end
            end else begin
               stalled = 1;
               held.data = m_if.tdata;
               held.key  = m_key;
            end
         end
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin : stimulus
      s_if.tvalid = 0; s_if.tdata = '0; s_if.tstrb = '0; s_if.tuser = '0; s_if.tlast = 0;
      m_if.tready = 1'b1;
      model_reset();
      repeat (3) @(posedge axi_aclk);
      #1;
      check("rst_m_tvalid", m_if.tvalid, 1'b0);
      check("rst_m_tdata", m_if.tdata, '0);
      check("rst_m_key", m_key, '0);
      check("rst_epoch", key_epoch, '0);
      check("rst_pending", commit_pending, 1'b0);
      axi_reset = 1'b0;
      idle(2);

      // Load 0x11111111..0x44444444 and commit.
      for (int i = 0; i < NK; i++) begin
         cfg_wr_en = 1'b1; cfg_wr_idx = 2'(i); cfg_wr_key = 32'h11111111 * (i + 1);
         cycle();
      end
      cfg_commit = 1'b1;
      cycle();
      idle(2);
      check("commit_done_pending", commit_pending, 1'b0);
      check("commit_done_epoch", key_epoch, 8'd1);
      send_pkt(3, 8'h04);   // expected key 0x22222222
      idle(3);

      // Mid-packet commit: old key 0xA on all beats, 0xB on next packet.
      cfg_wr_en = 1'b1; cfg_wr_idx = 2'd0; cfg_wr_key = 32'hA; cfg_commit = 1'b1;
      cycle();
      idle(2);
      s_if.tuser = mk_user(8'h01);
      send_beat(s_if.tuser, 0);
      cfg_wr_en = 1'b1; cfg_wr_idx = 2'd0; cfg_wr_key = 32'hB; cfg_commit = 1'b1;
      send_beat(s_if.tuser, 0);
      send_beat(s_if.tuser, 0);
      check("midpkt_pending", commit_pending, 1'b1);
      send_beat(s_if.tuser, 1);
      send_pkt(2, 8'h01);
      idle(3);

      // Backpressure during a 5-beat packet.
      rdy_pat = '{1, 0, 0, 1, 0, 1};
      send_pkt(5, 8'h10);
      idle(4);

      // Back-to-back one-beat packets at full rate.
      send_pkt(1, 8'h01);
      send_pkt(1, 8'h02);
      send_pkt(1, 8'h40);
      idle(3);

      // Randomized traffic with random backpressure and config activity.
      rand_mode = 1'b1;
      for (int p = 0; p < 150; p++) begin
         logic [7:0] fld;
         fld = ($urandom_range(5) == 0) ? 8'h00 : 8'($urandom);
         send_pkt($urandom_range(1, 4), fld);
         if ($urandom_range(2) == 0) idle($urandom_range(1, 3));
      end
      rand_mode = 1'b0;
      idle(6);

      // Reset during beat 2 with the output stalled.
      rdy_pat = '{0};
      s_if.tuser = mk_user(8'h08);
      send_beat(s_if.tuser, 0);
      s_if.tlast = 0;
      axi_reset = 1'b1;
      #1;
      check("arst_m_tvalid", m_if.tvalid, 1'b0);
      check("arst_epoch", key_epoch, '0);
      check("arst_pending", commit_pending, 1'b0);
      check("arst_m_key", m_key, '0);
      s_if.tvalid = 1'b0;
      exp_q.delete();
      rdy_pat.delete();
      model_reset();
      repeat (2) @(posedge axi_aclk);
      #1;
      axi_reset = 1'b0;
      m_if.tready = 1'b1;
      idle(1);
      send_pkt(1, 8'h00);   // no source: key entry 0, which is zero after reset
      idle(2);
`ifdef CRYPTO_KEY_STATS_EN
      check("stats_nosrc", nosrc_count, 16'd1);
      check("stats_pkt", pkt_count, 32'd1);
`endif
      send_pkt(2, 8'h04);
      idle(4);
      check("queue_drained", exp_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/crypto_key_scheduler.md
Name: crypto_key_scheduler

Overview:
- Sits immediately upstream of the crypto output_port_lookup datapath on the 256-bit AXI4-Stream.
- Holds a per-interface 32-bit key table and selects the key on each packet's first beat, using the source-port one-hot in tuser.
- Presents that key, beat-aligned and stable for the whole packet, alongside a registered copy of the stream.
- Host key updates are double-buffered: a commit swaps the tables only at a packet boundary.

Parameters:
C_AXIS_DATA_WIDTH, 256, stream data width (tstrb = /8)
C_AXIS_TUSER_WIDTH, 128, tuser width
NUM_KEYS, 4, number of interfaces/keys (power of 2, 2..8)
SRC_PORT_POS, 16, lsb of source-port one-hot field in tuser (2*NUM_KEYS bits wide)

Ports:
axi_aclk  in  1  clock
axi_reset  in  1  asynchronous active-high reset
s_axis_tdata/tstrb/tuser  in  256/32/128  upstream beat
s_axis_tvalid, s_axis_tlast  in  1 each  upstream valid, end of packet
s_axis_tready  out  1  upstream ready
m_axis_tdata/tstrb/tuser  out  256/32/128  registered beat to crypto datapath
m_axis_tvalid, m_axis_tlast  out  1 each  downstream valid, end of packet
m_axis_tready  in  1  downstream ready
m_key  out  32  key for the current m_axis beat
cfg_wr_en  in  1  write cfg_wr_key into shadow[cfg_wr_idx]
cfg_wr_idx  in  log2(NUM_KEYS)  shadow entry index
cfg_wr_key  in  32  key value
cfg_commit  in  1  pulse: request shadow->active copy
commit_pending  out  1  commit requested, not yet applied
key_epoch  out  8  count of applied commits (wraps)

Behaviour:
- Reset (async, active-high):
  - m_axis_tvalid=0, m_axis_tdata/tstrb/tuser/tlast=0, m_key=0.
  - Both tables = 0, commit_pending=0, key_epoch=0, state=SOP.
- Register slice: s_axis_tready = !m_axis_tvalid || m_axis_tready.
  - Accept when s_axis_tvalid && s_axis_tready; the beat appears on m_axis the next cycle (latency 1).
  - m_axis outputs hold stable while tvalid && !tready.
  - Full throughput: a beat can be accepted every cycle.
- Input FSM (advances on accepted beats only):
  - SOP: beat accepted with tlast=0 -> MID; with tlast=1 -> stays SOP (one-beat packet).
  - MID: beat accepted with tlast=1 -> SOP.
- Key selection on an SOP beat:
  - f = tuser[SRC_PORT_POS +: 2*NUM_KEYS]; idx = (index of lowest set bit of f) >> 1, so MAC and DMA of one interface share a key.
  - f==0 -> idx=0.
  - cur_key <= active[idx]. MID beats reuse cur_key.
  - m_key is loaded together with each beat, so it always matches the beat on m_axis.
- Shadow writes: cfg_wr_en writes shadow at the clock edge, any time. They never affect active directly.
- Commit:
  - cfg_commit sets commit_pending.
  - Swap (active <= shadow for all entries, commit_pending <= 0, key_epoch += 1) happens at the end of the first cycle after the commit cycle where next_state==SOP.
  - An SOP lookup in the swap cycle uses the pre-swap table; the following packet uses the new keys.
  - Repeated commits while pending merge into one swap.
  - A shadow write in the swap cycle is not included in that swap.
- Simultaneous cfg_commit and swap eligibility in the same cycle: the swap is deferred to the next eligible cycle.
- Reset mid-packet: the packet is dropped, state returns to SOP, and all keys are cleared.

Optional Feature:
CRYPTO_KEY_STATS_EN
- Defined: adds outputs pkt_count[31:0] (increments on accepted tlast beats) and nosrc_count[15:0] (increments on SOP beats with f==0, saturating). Both are cleared by reset.
- Undefined: these ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared header crypto_defs.vh:
  - state encodings ST_SOP=0, ST_MID=1.
  - KEY_WIDTH=32, EPOCH_WIDTH=8.
  - default stream widths.
- Sub-module axis_reg_slice: the single-stage valid/ready register carrying {tlast, tuser, tstrb, tdata, key}, reusable elsewhere in the datapath.
- The key tables, FSM and commit logic stay in the top-level module.

Test Plan:
- Write shadow[0..3]=0x11111111..0x44444444, commit, idle 2 cycles -> commit_pending=0, key_epoch=1. A 3-beat packet with tuser[23:16]=0x04 -> m_key=0x22222222 on all 3 beats.
- Mid-packet commit: 4-beat packet from port 0 (old key 0xA), commit shadow[0]=0xB on beat 2. Result: all beats carry 0xA, commit_pending=1 until tlast is accepted, next packet carries 0xB.
- Backpressure: m_axis_tready toggles 1,0,0,1 during a 5-beat packet. m_axis data/m_key hold stable while stalled, no beat is lost or duplicated, and s_axis_tready=0 only while the output is full and stalled.
- Back-to-back one-beat packets from ports 0x01, 0x02, 0x40 (f=0x01 -> idx0, f=0x02 -> idx0, f=0x40 -> idx3) at full rate -> one output per cycle, m_key = active[0], active[0], active[3].
- tuser source field=0 -> key 0 is used; with CRYPTO_KEY_STATS_EN, nosrc_count=1 and pkt_count=1.
- Assert axi_reset during beat 2 of a packet -> m_axis_tvalid falls asynchronously, key_epoch=0, and the next packet's first beat is treated as SOP with m_key=0.
